// File: rtl/mvu_pkg.sv
// mvu_pkg: shared MVU widths and the APB command/response records used by the APB initiator.
package mvu_pkg;
   localparam int APB_ADDR_WIDTH = 32;
   localparam int APB_DATA_WIDTH = 32;

   typedef struct packed {
      logic                      write;
      logic [APB_ADDR_WIDTH-1:0] addr;
      logic [APB_DATA_WIDTH-1:0] wdata;
   } apb_cmd_t;

   typedef struct packed {
      logic [APB_DATA_WIDTH-1:0] rdata;
      logic                      err;
      logic                      timeout;
   } apb_rsp_t;
endpackage

// File: rtl/mvu_apb_master.sv
// mvu_apb_master: single-outstanding APB3 initiator bridging a cmd/rsp valid-ready stream to the MVU CSR slave.
module mvu_apb_master
   import mvu_pkg::*;
#(
   parameter int ADDR_WIDTH     = APB_ADDR_WIDTH,
   parameter int DATA_WIDTH     = APB_DATA_WIDTH,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [DATA_WIDTH-1:0] cmd_wdata,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  rsp_err,
   output logic                  rsp_timeout,
   output logic [ADDR_WIDTH-1:0] paddr,
   output logic [DATA_WIDTH-1:0] pwdata,
   output logic                  pwrite,
   output logic                  psel,
   output logic                  penable,
   input  logic [DATA_WIDTH-1:0] prdata,
   input  logic                  pready,
   input  logic                  pslverr,
   output logic                  busy
);
   localparam int WDW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [WDW-1:0] WD_LAST = TIMEOUT_CYCLES > 0 ? WDW'(TIMEOUT_CYCLES - 1) : '0;

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

   state_t         state, state_nx;
   logic           live;
   logic [WDW-1:0] wd;
   logic           expire, accept;

   // live keeps cmd_ready low for the reset cycle itself, so it only rises once rst_n is released
   assign cmd_ready = live && state == IDLE;
   assign accept    = cmd_valid && cmd_ready;
   assign expire    = TIMEOUT_CYCLES != 0 && wd == WD_LAST;
   assign psel      = state == SETUP || state == ACCESS;
   assign penable   = state == ACCESS;
   assign rsp_valid = state == RESP;
   assign busy      = state != IDLE;

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    state_nx = accept ? SETUP : IDLE;
         SETUP:   state_nx = ACCESS;
         ACCESS:  state_nx = pready || expire ? RESP : ACCESS;
         RESP:    state_nx = rsp_ready ? IDLE : RESP;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         live  <= 1'b0;
      end else begin
         state <= state_nx;
         live  <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         paddr       <= '0;
         pwdata      <= '0;
         pwrite      <= 1'b0;
         wd          <= '0;
         rsp_rdata   <= '0;
         rsp_err     <= 1'b0;
         rsp_timeout <= 1'b0;
      end else begin
         if (accept) begin
            paddr  <= cmd_addr;
            pwdata <= cmd_wdata;
            pwrite <= cmd_write;
            wd     <= '0;
         end
         if (state == ACCESS) begin
            // pready is checked first so a completion on the expiry cycle stays a normal response
            if (pready) begin
               rsp_rdata   <= pwrite ? '0 : prdata;
               rsp_err     <= pslverr;
               rsp_timeout <= 1'b0;
            end else begin
               if (wd != '1) wd <= wd + WDW'(1);
               if (expire) begin
                  rsp_rdata   <= '0;
                  rsp_err     <= 1'b1;
                  rsp_timeout <= 1'b1;
               end
            end
         end
      end
   end
endmodule

// File: tb/tb_mvu_apb_master.sv
// tb_mvu_apb_master: randomized transfers against a per-transfer expectation model of the APB initiator.
module tb_mvu_apb_master;
   localparam int TO = 8;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
   logic [31:0] cmd_addr = '0, cmd_wdata = '0;
   logic        rsp_valid, rsp_ready = 1'b0;
   logic [31:0] rsp_rdata;
   logic        rsp_err, rsp_timeout;
   logic [31:0] paddr, pwdata;
   logic        pwrite, psel, penable;
   logic [31:0] prdata = '0;
   logic        pready = 1'b0, pslverr = 1'b0;
   logic        busy;
   int          n_chk = 0, n_err = 0;

   mvu_apb_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
      .paddr(paddr), .pwdata(pwdata), .pwrite(pwrite), .psel(psel), .penable(penable),
      .prdata(prdata), .pready(pready), .pslverr(pslverr), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // waits = low-pready ACCESS cycles before completion; waits >= TO means the slave never answers
   task automatic do_xfer(input bit w, input logic [31:0] a, input logic [31:0] d, input int waits,
                          input logic [31:0] rd, input bit se, input int dly);
      int          k;
      bit          to;
      logic [31:0] er;
      to = waits >= TO;
      er = (to || w) ? 32'h0 : rd;
      cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
      k = 0;
      while (!cmd_ready && k < 10) begin
         @(negedge clk);
         k++;
      end
      if (!cmd_ready) begin
         check("accept_bound", 0, 1);
         cmd_valid = 1'b0;
         return;
      end
      @(negedge clk);
      cmd_valid = 1'($urandom); cmd_write = 1'($urandom); cmd_addr = $urandom; cmd_wdata = $urandom;
      pready = 1'($urandom); prdata = $urandom;
      check("setup_phase", {psel, penable, busy, rsp_valid}, 4'b1010);
      check("setup_req", {pwrite, paddr, pwdata}, {w, a, d});
      @(negedge clk);
      k = 0;
      while (psel && penable && k < 20) begin
         check("access_req", {pwrite, paddr, pwdata}, {w, a, d});
         pready  = k == waits;
         prdata  = k == waits ? rd : $urandom;
         pslverr = k == waits ? se : 1'($urandom);
         k++;
         @(negedge clk);
      end
      pready = 1'b0; pslverr = 1'b0;
      check("access_len", k, to ? TO : waits + 1);
      for (int i = 0; i <= dly; i++) begin
         check("rsp_phase", {rsp_valid, psel, penable, cmd_ready, busy}, 5'b10001);
         check("rsp_fields", {rsp_rdata, rsp_err, rsp_timeout}, {er, to | se, to});
         if (i == dly) rsp_ready = 1'b1;
         @(negedge clk);
      end
      rsp_ready = 1'b0; cmd_valid = 1'b0;
      check("rsp_done", {rsp_valid, cmd_ready, busy, psel}, 4'b0100);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check("reset_outs", {cmd_ready, rsp_valid, psel, penable, busy, rsp_err, rsp_timeout}, 0);
      check("reset_regs", {paddr, pwdata, rsp_rdata}, 0);
      rst_n = 1'b1;
      @(negedge clk);
      check("ready_after_reset", {cmd_ready, busy}, 2'b10);

      do_xfer(1'b1, 32'h10, 32'hDEADBEEF, 0, 32'h1234, 1'b0, 0);
      do_xfer(1'b0, 32'h24, 32'h0, 3, 32'h0000A5A5, 1'b0, 0);
      do_xfer(1'b0, 32'h7FF, 32'h0, 1, 32'h5555AAAA, 1'b1, 1);
      do_xfer(1'b0, 32'h40, 32'h0, 20, 32'h0, 1'b0, 0);
      do_xfer(1'b0, 32'h44, 32'h0, 0, 32'hCAFEF00D, 1'b0, 0);
      do_xfer(1'b0, 32'h48, 32'h0, TO - 1, 32'h600DD00D, 1'b0, 0);
      do_xfer(1'b1, 32'h50, 32'h01020304, 2, 32'h0, 1'b0, 10);
      do_xfer(1'b1, 32'h54, 32'h05060708, 0, 32'h0, 1'b0, 0);

      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h60; cmd_wdata = '0;
      @(negedge clk);
      cmd_valid = 1'b0;
      repeat (3) @(negedge clk);
      check("pre_reset_access", {psel, penable}, 2'b11);
      rst_n = 1'b0;
      @(negedge clk);
      check("midreset_outs", {cmd_ready, rsp_valid, psel, penable, busy, rsp_err, rsp_timeout}, 0);
      check("midreset_regs", {paddr, pwdata, rsp_rdata}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("ready_after_midreset", cmd_ready, 1);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("no_stale_rsp", {rsp_valid, busy, psel}, 0);
      end

      for (int n = 0; n < 40; n++)
         do_xfer(1'($urandom), $urandom, $urandom, $urandom_range(0, 10), $urandom,
                 1'($urandom), $urandom_range(0, 3));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end
endmodule

// File: doc/mvu_apb_master.md
# mvu_apb_master

APB3 initiator that turns a valid/ready command stream into single APB transfers towards the MVU configuration slave (`mvutop_wrapper` APB port), returning read data and error status on a valid/ready response stream. It sits between a host-side controller and the MVU so that RTL, not only the bench driver, can program MVU CSRs. One transfer is outstanding at a time. A watchdog aborts transfers whose slave never asserts `pready`.

## Interface
- `ADDR_WIDTH`, default `mvu_pkg::APB_ADDR_WIDTH`: APB address width.
- `DATA_WIDTH`, default `mvu_pkg::APB_DATA_WIDTH`: APB data width.
- `TIMEOUT_CYCLES`, default 256: maximum ACCESS cycles before abort; 0 disables the watchdog.

Ports:
- `clk` in 1: single clock for all logic.
- `rst_n` in 1: synchronous, active-low reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: command accepted this cycle when both `cmd_valid` and `cmd_ready` are high.
- `cmd_write` in 1: 1 = write, 0 = read.
- `cmd_addr` in ADDR_WIDTH: target CSR address.
- `cmd_wdata` in DATA_WIDTH: write data.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: response consumed.
- `rsp_rdata` out DATA_WIDTH: read data; 0 for writes and timeouts.
- `rsp_err` out 1: `pslverr` was seen, or the watchdog timed out.
- `rsp_timeout` out 1: the transfer was aborted by the watchdog.
- `paddr` out ADDR_WIDTH, `pwrite` out 1, `pwdata` out DATA_WIDTH, `psel` out 1, `penable` out 1: APB request signals.
- `prdata` in DATA_WIDTH, `pready` in 1, `pslverr` in 1: APB completion signals.
- `busy` out 1: high in any state except IDLE.

## Operation
States: IDLE, SETUP, ACCESS, RESP.
- **IDLE:** `cmd_ready`=1.
  - On handshake, latch `cmd_write`/`cmd_addr`/`cmd_wdata` into the `paddr`/`pwrite`/`pwdata` registers, clear the watchdog, and go to SETUP.
- **SETUP:** `psel`=1, `penable`=0. Always go to ACCESS next cycle.
- **ACCESS:** `psel`=1, `penable`=1.
  - On `pready`=1, capture the response and go to RESP:
    - `rsp_rdata` = `pwrite` ? 0 : `prdata`
    - `rsp_err` = `pslverr`
    - `rsp_timeout` = 0
  - Otherwise increment the watchdog. When the watchdog reaches TIMEOUT_CYCLES (TIMEOUT_CYCLES≠0), go to RESP with `rsp_err`=1, `rsp_timeout`=1, `rsp_rdata`=0.
- **RESP:** `rsp_valid`=1 and `psel`=`penable`=0. Response fields are held stable until `rsp_ready`=1, then go to IDLE.
- `paddr`/`pwrite`/`pwdata` stay constant from SETUP through the end of ACCESS.
- Watchdog width is $clog2(TIMEOUT_CYCLES+1). It saturates and never wraps.

## Timing
- **Reset value of every output:** 0 (`cmd_ready`, `rsp_*`, `p*`, `busy`). `cmd_ready` rises in the first cycle after `rst_n` deasserts.
- **Minimum latency:**
  - Handshake at edge T; SETUP in cycle T+1; ACCESS in cycle T+2.
  - With zero-wait `pready`, `rsp_valid` is high in cycle T+3.
  - If `rsp_ready` is already high, IDLE is reached at T+4, giving a peak rate of 1 transfer per 4 cycles.
- **Wait states:** each low-`pready` cycle in ACCESS adds one cycle. `pready` is sampled only in ACCESS; `pready` in SETUP or IDLE is ignored.
- **Timeout:** with TIMEOUT_CYCLES=N and `pready` never asserted, ACCESS lasts exactly N cycles. `psel` drops and `rsp_valid` rises in the following cycle.
- **No combinational paths** from `cmd_valid` to `cmd_ready` or from `rsp_ready` to `cmd_ready`. A new command is never accepted in the same cycle as the response handshake.
- **Backpressure:** `rsp_valid` is never withdrawn without `rsp_ready`. `cmd_*` inputs are ignored outside IDLE.
- **Reset mid-transfer:** `rst_n` low at any edge forces IDLE with all outputs 0 at that edge. Any pending response is dropped. The APB slave sees `psel` fall without completion.
- **Same-cycle events:** `pready` and watchdog expiry in the same ACCESS cycle → `pready` wins, and the response is normal.

## Structure
- `mvu_pkg` supplies `APB_ADDR_WIDTH` and `APB_DATA_WIDTH`. It also gets two new packed structs:
  - `apb_cmd_t`: write, addr, wdata.
  - `apb_rsp_t`: rdata, err, timeout.
- The state enum stays local to the module.
- Single module, no sub-modules. The watchdog is an inline saturating counter.
- Pin order of the APB signals follows the `APB` interface so that the top level can bind with `APB_ASSIGN`-style macros.
- Estimated 150–250 lines.

## Test plan
- **Zero-wait write:** write `cmd_addr`=0x10, `cmd_wdata`=0xDEADBEEF, slave `pready` always 1 → `psel` in T+1..T+2, `penable` only in T+2, `rsp_valid` at T+3, `rsp_rdata`=0, `rsp_err`=0.
- **Wait-state read:** read 0x24, slave inserts 3 wait states and returns `prdata`=0x0000A5A5 → ACCESS lasts 4 cycles, address stable throughout, `rsp_rdata`=0xA5A5.
- **Slave error:** read 0x7FF with `pslverr`=1 at `pready` → `rsp_err`=1, `rsp_timeout`=0, `rsp_rdata`=`prdata`.
- **Watchdog:** TIMEOUT_CYCLES=8, `pready` held 0 → exactly 8 ACCESS cycles, then `rsp_err`=`rsp_timeout`=1. The next command completes normally.
- **Response backpressure:** `rsp_ready` held low 10 cycles, `cmd_valid` held high with a second command → `cmd_ready`=0 and `psel`=0 throughout, response stable. The second command is accepted the cycle after `rsp_ready`.
- **Reset mid-ACCESS:** `rst_n`=0 during a wait state → all outputs 0 at the next edge, `cmd_ready`=1 the cycle after release, and no stale response is emitted.
